seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller that shares one hex-to-7-segment decoder across NUM_DIGITS

---
 rtl/seg7_scan_pkg.sv | 21 ++
 rtl/seg7_scan_prescaler.sv | 29 ++
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared state type, nibble width and one-hot helper for the
// 7-segment scan controller.
package seg7_scan_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 32;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // One-hot vector with bit idx set; callers size-cast down to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    logic [MAX_DIGITS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seg7_scan_prescaler.sv
// seg7_scan_prescaler: tick generator for the scan FSM. The count wraps when it
// reaches or passes the prescale value, so a lowered prescale takes effect at
// once instead of running the counter all the way round.
module seg7_scan_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = !clear && (cnt >= prescale);

  // Count clocks between ticks; held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-cathode digits
// through one shared hex decoder. Writes land in a shadow bank and are copied
// to the displayed (active) bank only at a frame boundary, so a frame never
// mixes old and new digits.
//
// Optional build macro SEG7_SCAN_AUTOCOUNT_EN: adds auto_en; with it set and
// no pending write, the active bank counts up as a hex counter once per frame.
//
// state | meaning
// BLANK | all digits off for one tick between digits (ghosting guard)
// SHOW  | digit idx driven for DWELL_TICKS ticks with a stable nibble
module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE_W  = 8,
  parameter int DWELL_TICKS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PRESCALE_W-1:0]         prescale,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
  input  logic [3:0]                    wr_data,
  output logic [3:0]                    dec_nibble,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_done
`ifdef SEG7_SCAN_AUTOCOUNT_EN
  ,
  input  logic                          auto_en
`endif
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BANK_W  = NUM_DIGITS * NIBBLE_W;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL_TICKS - 1);

  scan_state_t        state;
  logic [IDX_W-1:0]   idx;
  logic [DWELL_W-1:0] dwell;
  logic [BANK_W-1:0]  active_bank;
  logic [BANK_W-1:0]  shadow_bank;
  logic               dirty;
  logic               tick;
  logic               show_done;
  logic               frame_end;
  logic               wr_fire;

  seg7_scan_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!enable),
    .prescale (prescale),
    .tick     (tick)
  );

  assign show_done = tick && (state == SHOW) && (dwell == LAST_DWELL);
  assign frame_end = show_done && (idx == LAST_IDX);
  assign wr_fire   = wr_valid && wr_ready;

  // Scan FSM: BLANK for one tick, then SHOW the current digit for DWELL_TICKS ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= '0;
      dwell      <= '0;
      dec_nibble <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        // idx is kept so scanning resumes on the same digit.
        state    <= BLANK;
        digit_en <= '0;
        dwell    <= '0;
      end else if (tick) begin
        case (state)
          BLANK: begin
            state      <= SHOW;
            dec_nibble <= active_bank[idx*NIBBLE_W +: NIBBLE_W];
            digit_en   <= NUM_DIGITS'(onehot(32'(idx)));
            dwell      <= '0;
          end
          SHOW: begin
            if (dwell == LAST_DWELL) begin
              state      <= BLANK;
              digit_en   <= '0;
              idx        <= idx + IDX_W'(1);
              frame_done <= frame_end;
            end else begin
              dwell <= dwell + DWELL_W'(1);
            end
          end
          default: begin
            state    <= BLANK;
            digit_en <= '0;
          end
        endcase
      end
    end
  end

  // Writes are refused only during the commit cycle that follows a frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b1;
    end else begin
      wr_ready <= !frame_end;
    end
  end

  // Shadow/active banks: writes go to shadow, whole bank commits at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank <= '0;
      shadow_bank <= '0;
      dirty       <= 1'b0;
    end else begin
      if (frame_end) begin
        if (dirty) begin
          active_bank <= shadow_bank;
        end
`ifdef SEG7_SCAN_AUTOCOUNT_EN
        else if (auto_en) begin
          active_bank <= active_bank + BANK_W'(1);
          shadow_bank <= active_bank + BANK_W'(1);
        end
`endif
      end
      // A write landing on the frame-end edge misses this commit and stays pending.
      if (wr_fire) begin
        shadow_bank[wr_digit*NIBBLE_W +: NIBBLE_W] <= wr_data;
        dirty <= 1'b1;
      end else if (frame_end) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] prescale;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_data;
  logic [3:0] dec_nibble;
  logic [3:0] digit_en;
  logic       frame_done;
`ifdef SEG7_SCAN_AUTOCOUNT_EN
  logic       auto_en;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nib;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .PRESCALE_W (8),
    .DWELL_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .prescale   (prescale),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digit   (wr_digit),
    .wr_data    (wr_data),
    .dec_nibble (dec_nibble),
    .digit_en   (digit_en),
    .frame_done (frame_done)
`ifdef SEG7_SCAN_AUTOCOUNT_EN
    ,
    .auto_en    (auto_en)
`endif
  );

  always #5 clk = ~clk;

  // Expected digit_en after n ticks from a fresh BLANK at digit 0:
  // each digit takes 4 ticks (3 SHOW then 1 BLANK).
  function automatic logic [3:0] en_of(int n);
    int t;
    if (n <= 0) return 4'b0000;
    t = n - 1;
    if (t % 4 == 3) return 4'b0000;
    return 4'(1 << ((t / 4) % 4));
  endfunction

  function automatic int digit_of(int n);
    return ((n - 1) / 4) % 4;
  endfunction

  function automatic int frame_of(int n);
    return (n - 1) / 16;
  endfunction

  task automatic do_reset(input logic en, input logic [7:0] ps);
    rst_n    = 1'b0;
    enable   = en;
    prescale = ps;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_data  = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    prescale = 8'd0;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_data  = 4'h0;
    repeat (2) @(negedge clk);
    total++;
    if ({digit_en, dec_nibble, frame_done, wr_ready} !== {4'b0000, 4'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_vals en/nib/fd/rdy got %b/%h/%b/%b want 0000/0/0/1",
               digit_en, dec_nibble, frame_done, wr_ready);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (digit_en !== 4'b0010) begin
      bad++;
      $display("FAIL reset_run en got %b want 0010", digit_en);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({digit_en, frame_done, wr_ready} !== {4'b0000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async en/fd/rdy got %b/%b/%b want 0000/0/1",
               digit_en, frame_done, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (digit_en !== 4'b0001) begin
      bad++;
      $display("FAIL reset_restart en got %b want 0001", digit_en);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    do_reset(1'b1, 8'd0);
    for (int k = 1; k <= 32; k++)
      sb.push_back('{en: en_of(k), nib: 4'h0, fd: (k % 16 == 0), rdy: (k % 16 != 0)});
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL scan k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (e.en != 4'b0000) begin
        total++;
        if (dec_nibble !== e.nib) begin
          bad++;
          $display("FAIL scan_nib k=%0d got %h want %h", k, dec_nibble, e.nib);
        end
      end
    end
  endtask

  // d2=A mid-frame plus two writes to d0 (last one wins); all visible next frame.
  task automatic test_write_commit();
    exp_t e;
    logic [3:0] b2 [4];
    logic [3:0] nib;
    b2 = '{4'hC, 4'h0, 4'hA, 4'h0};
    do_reset(1'b1, 8'd0);
    for (int k = 1; k <= 32; k++) begin
      nib = (frame_of(k) == 0) ? 4'h0 : b2[digit_of(k)];
      sb.push_back('{en: en_of(k), nib: nib, fd: (k % 16 == 0), rdy: (k % 16 != 0)});
    end
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL write k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (e.en != 4'b0000) begin
        total++;
        if (dec_nibble !== e.nib) begin
          bad++;
          $display("FAIL write_nib k=%0d got %h want %h", k, dec_nibble, e.nib);
        end
      end
      case (k)
        5: begin wr_valid = 1'b1; wr_digit = 2'd2; wr_data = 4'hA; end
        6: begin wr_digit = 2'd0; wr_data = 4'h1; end
        7: wr_data = 4'hC;
        8: wr_valid = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Writes offered during a commit cycle are refused; a retry is taken next clock.
  task automatic test_commit_edge();
    exp_t e;
    logic [3:0] nib;
    do_reset(1'b1, 8'd0);
    for (int k = 1; k <= 64; k++) begin
      nib = (frame_of(k) >= 2 && digit_of(k) == 1) ? 4'h5 : 4'h0;
      sb.push_back('{en: en_of(k), nib: nib, fd: (k % 16 == 0), rdy: (k % 16 != 0)});
    end
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL commit_edge k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (e.en != 4'b0000) begin
        total++;
        if (dec_nibble !== e.nib) begin
          bad++;
          $display("FAIL commit_edge_nib k=%0d got %h want %h", k, dec_nibble, e.nib);
        end
      end
      case (k)
        16: begin wr_valid = 1'b1; wr_digit = 2'd1; wr_data = 4'h5; end
        18: wr_valid = 1'b0;
        32: begin wr_valid = 1'b1; wr_digit = 2'd3; wr_data = 4'h9; end
        33: wr_valid = 1'b0;
        default: ;
      endcase
    end
  endtask

  // prescale 7 -> 2 while the count sits at 5: tick on the next clock, then every 3.
  task automatic test_prescale_change();
    exp_t e;
    int n;
    do_reset(1'b1, 8'd7);
    for (int k = 1; k <= 30; k++) begin
      n = (k < 6) ? 0 : (k - 6) / 3 + 1;
      sb.push_back('{en: en_of(n), nib: 4'h0, fd: 1'b0, rdy: 1'b1});
    end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL prescale k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (k == 5) prescale = 8'd2;
    end
  endtask

  // Disable during digit1 SHOW, re-enable: resumes with a fresh SHOW of digit1.
  task automatic test_enable();
    exp_t e;
    int n;
    logic fd;
    do_reset(1'b1, 8'd0);
    for (int k = 1; k <= 24; k++) begin
      n  = (k <= 5) ? k : ((k <= 9) ? -1 : k - 5);
      fd = (n > 0) && (n % 16 == 0);
      sb.push_back('{en: en_of(n), nib: 4'h0, fd: fd, rdy: !fd});
    end
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL enable k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (k == 5) enable = 1'b0;
      if (k == 9) enable = 1'b1;
    end
  endtask

`ifdef SEG7_SCAN_AUTOCOUNT_EN
  // Load 000F by commit, count to 0010; load FFFF (commit beats count), wrap to 0000.
  task automatic test_autocount();
    exp_t e;
    logic [15:0] banks [5];
    logic [15:0] bk;
    logic [3:0]  nib;
    banks = '{16'h0000, 16'h000F, 16'h0010, 16'hFFFF, 16'h0000};
    auto_en = 1'b1;
    do_reset(1'b1, 8'd0);
    for (int k = 1; k <= 80; k++) begin
      bk  = banks[frame_of(k)];
      nib = bk[digit_of(k)*4 +: 4];
      sb.push_back('{en: en_of(k), nib: nib, fd: (k % 16 == 0), rdy: (k % 16 != 0)});
    end
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({digit_en, frame_done, wr_ready} !== {e.en, e.fd, e.rdy}) begin
        bad++;
        $display("FAIL autocount k=%0d en/fd/rdy got %b/%b/%b want %b/%b/%b",
                 k, digit_en, frame_done, wr_ready, e.en, e.fd, e.rdy);
      end
      if (e.en != 4'b0000) begin
        total++;
        if (dec_nibble !== e.nib) begin
          bad++;
          $display("FAIL autocount_nib k=%0d got %h want %h", k, dec_nibble, e.nib);
        end
      end
      case (k)
        2:  begin wr_valid = 1'b1; wr_digit = 2'd0; wr_data = 4'hF; end
        3:  wr_valid = 1'b0;
        34: begin wr_valid = 1'b1; wr_digit = 2'd0; wr_data = 4'hF; end
        35: wr_digit = 2'd1;
        36: wr_digit = 2'd2;
        37: wr_digit = 2'd3;
        38: wr_valid = 1'b0;
        default: ;
      endcase
    end
    auto_en = 1'b0;
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    prescale = 8'd0;
    wr_valid = 1'b0;
    wr_digit = 2'd0;
    wr_data  = 4'h0;
`ifdef SEG7_SCAN_AUTOCOUNT_EN
    auto_en  = 1'b0;
`endif
    test_reset();
    test_scan();
    test_write_commit();
    test_commit_edge();
    test_prescale_change();
    test_enable();
`ifdef SEG7_SCAN_AUTOCOUNT_EN
    test_autocount();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
